// File: rtl/mux_arbiter_16_pkg.sv
// Shared definitions for the two-requester packet arbiter: FSM state
// encoding and the default data path width.
package mux_arbiter_16_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

endpackage

// File: rtl/mux_arbiter_16_mux.sv
// Two-input data multiplexer: select=0 passes in0, select=1 passes in1.
module multiplexer_16
    import mux_arbiter_16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             select,
    output logic [WIDTH-1:0] out
);

    assign out = select ? in1 : in0;

endmodule

// File: rtl/mux_arbiter_16.sv
// Packet-locked round-robin arbiter for two valid/ready requesters feeding
// one registered output stage. A grant is held until the beat flagged last
// is accepted; the FSM then returns to IDLE for one bubble cycle and the
// round-robin pointer moves to the other requester.
module mux_arbiter_16
    import mux_arbiter_16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);

    state_t         state;
    logic           prio;
    logic           sink_free;
    logic           grant_sel;
    logic           accept;
    logic [WIDTH:0] sel_beat;

    // The output register can take a new beat when empty or being drained.
    assign sink_free = !out_valid || out_ready;
    assign in0_ready = (state == GRANT0) && sink_free;
    assign in1_ready = (state == GRANT1) && sink_free;
    assign grant_sel = (state == GRANT1);
    assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);

    // last flag rides along with the data as the MSB of the muxed beat
    multiplexer_16 #(
        .WIDTH (WIDTH + 1)
    ) u_data_mux (
        .in0    ({in0_last, in0_data}),
        .in1    ({in1_last, in1_data}),
        .select (grant_sel),
        .out    (sel_beat)
    );

    // Arbitration FSM: pick a requester in IDLE, hold it until its last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in0_valid && in1_valid)
                        state <= prio ? GRANT1 : GRANT0;
                    else if (in0_valid)
                        state <= GRANT0;
                    else if (in1_valid)
                        state <= GRANT1;
                end
                GRANT0: begin
                    if (accept && sel_beat[WIDTH]) begin
                        state <= IDLE;
                        prio  <= 1'b1;
                    end
                end
                GRANT1: begin
                    if (accept && sel_beat[WIDTH]) begin
                        state <= IDLE;
                        prio  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on acceptance, clear once drained, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_beat[WIDTH-1:0];
            out_last  <= sel_beat[WIDTH];
            out_src   <= grant_sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arbiter_16.sv
// Directed bench for mux_arbiter_16: a per-cycle vector table followed by
// hand-written sequences driven through small requester queues and checked
// against hand-built expected output beat lists.
module tb_mux_arbiter_16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in0_valid = 1'b0, in0_last = 1'b0, in0_ready;
    logic [W-1:0] in0_data = '0;
    logic         in1_valid = 1'b0, in1_last = 1'b0, in1_ready;
    logic [W-1:0] in1_data = '0;
    logic         out_valid, out_last, out_src;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    mux_arbiter_16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v0; logic [W-1:0] d0; logic l0;
        logic         v1; logic [W-1:0] d1; logic l1;
        logic         ordy;
        logic         er0; logic er1; logic eov; logic eol; logic eos;
        logic [W-1:0] eod;
    } vec_t;

    typedef struct packed { logic last; logic [W-1:0] data; } beat_t;
    typedef struct packed { logic src; logic last; logic [W-1:0] data; } obs_t;

    beat_t q0[$], q1[$];
    obs_t  obs[$], expq[$];
    vec_t  vecs[14];

    function automatic vec_t mk(input logic v0, input int d0, input logic l0,
                                input logic v1, input int d1, input logic l1,
                                input logic ordy,
                                input logic er0, input logic er1, input logic eov,
                                input int eod, input logic eol, input logic eos);
        vec_t v;
        v.v0 = v0; v.d0 = d0[W-1:0]; v.l0 = l0;
        v.v1 = v1; v.d1 = d1[W-1:0]; v.l1 = l1;
        v.ordy = ordy;
        v.er0 = er0; v.er1 = er1; v.eov = eov;
        v.eod = eod[W-1:0]; v.eol = eol; v.eos = eos;
        return v;
    endfunction

    function automatic beat_t mkb(input int d, input logic l);
        beat_t b;
        b.data = d[W-1:0];
        b.last = l;
        return b;
    endfunction

    function automatic obs_t mko(input logic s, input int d, input logic l);
        obs_t o;
        o.src = s; o.data = d[W-1:0]; o.last = l;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Present queue heads for one cycle; record handshakes at the falling edge.
    task automatic step(input logic ordy);
        obs_t o;
        if (q0.size() > 0) begin
            in0_valid = 1'b1; in0_data = q0[0].data; in0_last = q0[0].last;
        end else begin
            in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
        end
        if (q1.size() > 0) begin
            in1_valid = 1'b1; in1_data = q1[0].data; in1_last = q1[0].last;
        end else begin
            in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
        end
        out_ready = ordy;
        @(negedge clk);
        if (in0_valid && in0_ready) void'(q0.pop_front());
        if (in1_valid && in1_ready) void'(q1.pop_front());
        if (out_valid && out_ready) begin
            o.src = out_src; o.last = out_last; o.data = out_data;
            obs.push_back(o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (c < 60 && (q0.size() != 0 || q1.size() != 0 || out_valid)) begin
            step(1'b1);
            c++;
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        check({name, " drain"}, 32'(q0.size() + q1.size() + int'(out_valid)), 32'd0);
    endtask

    task automatic check_beats(input string name);
        check({name, " beat count"}, 32'(obs.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < obs.size(); i++)
            check($sformatf("%s beat %0d {src,last,data}", name, i),
                  32'(obs[i]), 32'(expq[i]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
        out_ready = 1'b0;
        q0.delete(); q1.delete(); obs.delete(); expq.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: both requesters send 1-beat packets (256 / 1024), then a
        // mid-packet valid drop and a 2-beat packet from requester 0.
        //             v0 d0   l0 v1 d1    l1 rdy | r0 r1 ov od    ol os
        vecs[0]  = mk(1, 256, 1, 1, 1024, 1, 1,   0, 0, 0, 0,    0, 0);
        vecs[1]  = mk(1, 256, 1, 1, 1024, 1, 1,   1, 0, 0, 0,    0, 0);
        vecs[2]  = mk(1, 256, 1, 1, 1024, 1, 1,   0, 0, 1, 256,  1, 0);
        vecs[3]  = mk(1, 256, 1, 1, 1024, 1, 1,   0, 1, 0, 256,  1, 0);
        vecs[4]  = mk(1, 256, 1, 1, 1024, 1, 1,   0, 0, 1, 1024, 1, 1);
        vecs[5]  = mk(1, 256, 1, 1, 1024, 1, 1,   1, 0, 0, 1024, 1, 1);
        vecs[6]  = mk(1, 256, 1, 1, 1024, 1, 1,   0, 0, 1, 256,  1, 0);
        vecs[7]  = mk(1, 256, 1, 1, 1024, 1, 1,   0, 1, 0, 256,  1, 0);
        vecs[8]  = mk(1, 256, 1, 1, 1024, 1, 1,   0, 0, 1, 1024, 1, 1);
        vecs[9]  = mk(0, 0,   0, 0, 0,    0, 1,   1, 0, 0, 1024, 1, 1);
        vecs[10] = mk(1, 7,   0, 0, 0,    0, 1,   1, 0, 0, 1024, 1, 1);
        vecs[11] = mk(1, 8,   1, 1, 1024, 1, 1,   1, 0, 1, 7,    0, 0);
        vecs[12] = mk(0, 0,   0, 0, 0,    0, 1,   0, 0, 1, 8,    1, 0);
        vecs[13] = mk(0, 0,   0, 0, 0,    0, 1,   0, 0, 0, 8,    1, 0);

        // Asynchronous reset takes effect without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset state {r0,r1,ov,ol,os,data}",
              32'({in0_ready, in1_ready, out_valid, out_last, out_src, out_data}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            in0_valid = vecs[i].v0; in0_data = vecs[i].d0; in0_last = vecs[i].l0;
            in1_valid = vecs[i].v1; in1_data = vecs[i].d1; in1_last = vecs[i].l1;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vector %0d {r0,r1,ov,ol,os,data}", i),
                  32'({in0_ready, in1_ready, out_valid, out_last, out_src, out_data}),
                  32'({vecs[i].er0, vecs[i].er1, vecs[i].eov, vecs[i].eol,
                       vecs[i].eos, vecs[i].eod}));
            @(posedge clk);
            #1;
        end

        // Single requester, single beat: output appears two edges after valid.
        do_reset();
        q0.push_back(mkb(256, 1'b1));
        step(1'b1);
        check("latency edge1 out_valid", 32'(out_valid), 32'd0);
        step(1'b1);
        check("latency edge2 {ov,src,last,data}",
              32'({out_valid, out_src, out_last, out_data}),
              32'({1'b1, 1'b0, 1'b1, 16'd256}));
        drain("single beat");

        // Grant locks on requester 1 for its whole 3-beat packet.
        do_reset();
        q1.push_back(mkb(1, 1'b0));
        q1.push_back(mkb(2, 1'b0));
        q1.push_back(mkb(3, 1'b1));
        step(1'b1);
        q0.push_back(mkb(16'h55, 1'b1));
        drain("lock");
        expq.push_back(mko(1'b1, 1, 1'b0));
        expq.push_back(mko(1'b1, 2, 1'b0));
        expq.push_back(mko(1'b1, 3, 1'b1));
        expq.push_back(mko(1'b0, 16'h55, 1'b1));
        check_beats("lock");

        // Back-pressure for 4 cycles mid-packet.
        do_reset();
        for (int i = 10; i <= 14; i++) q0.push_back(mkb(i, i == 14));
        repeat (3) step(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            check($sformatf("stall %0d {ov,r0,data}", i),
                  32'({out_valid, in0_ready, out_data}), 32'({1'b1, 1'b0, 16'd11}));
        end
        drain("stall");
        for (int i = 10; i <= 14; i++) expq.push_back(mko(1'b0, i, i == 14));
        check_beats("stall");

        // Reset pulse mid-packet, then arbitration restarts at requester 0.
        do_reset();
        q1.push_back(mkb(20, 1'b0));
        q1.push_back(mkb(21, 1'b0));
        q1.push_back(mkb(22, 1'b1));
        repeat (3) step(1'b1);
        check("pre-reset {ov,src,data}", 32'({out_valid, out_src, out_data}),
              32'({1'b1, 1'b1, 16'd21}));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-packet reset {r0,r1,ov,ol,os,data}",
              32'({in0_ready, in1_ready, out_valid, out_last, out_src, out_data}), 32'd0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        q0.delete(); q1.delete(); obs.delete(); expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q0.push_back(mkb(30, 1'b1));
        q1.push_back(mkb(40, 1'b1));
        drain("post reset");
        expq.push_back(mko(1'b0, 30, 1'b1));
        expq.push_back(mko(1'b1, 40, 1'b1));
        check_beats("post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_16.md
MUX_ARBITER_16 -- requirements
Module: mux_arbiter_16

Interface
REQ-001 Parameter: WIDTH, 16, data path width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in0_valid  input  1  requester 0 beat valid.
REQ-005 Port: in0_data  input  WIDTH  requester 0 beat data.
REQ-006 Port: in0_last  input  1  requester 0 final beat of packet.
REQ-007 Port: in0_ready  output  1  requester 0 beat accepted when in0_valid and in0_ready are both high.
REQ-008 Port: in1_valid, in1_data, in1_last, in1_ready  same widths and meaning as REQ-004..007, for requester 1.
REQ-009 Port: out_valid  output  1  registered output beat valid.
REQ-010 Port: out_data  output  WIDTH  registered output data.
REQ-011 Port: out_last  output  1  registered copy of the accepted beat's last flag.
REQ-012 Port: out_src  output  1  requester index of the current output beat.
REQ-013 Port: out_ready  input  1  sink accepts the output beat when out_valid and out_ready are both high.

Function
REQ-014 FSM states SHALL be IDLE, GRANT0, GRANT1.
REQ-015 In IDLE, in0_ready and in1_ready SHALL be 0 and no beat SHALL be accepted.
REQ-016 In IDLE with exactly one inN_valid high, next state SHALL be GRANTN.
REQ-017 In IDLE with both valid high, next state SHALL be GRANT(prio), where prio is the round-robin pointer.
REQ-018 In IDLE with no valid high, the FSM SHALL stay in IDLE.
REQ-019 In GRANTk, ink_ready SHALL equal (!out_valid | out_ready); the other requester's ready SHALL be 0.
REQ-020 An accepted beat SHALL load out_data, out_last and out_src=k and set out_valid=1 on the same edge (latency 1 cycle).
REQ-021 If out_valid=1 and out_ready=1 with no new beat accepted, out_valid SHALL clear on that edge.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_last and out_src SHALL hold stable.
REQ-023 Grant SHALL lock for the whole packet; the other requester's valid SHALL NOT affect the grant until the beat with ink_last=1 is accepted.
REQ-024 On acceptance of the last beat, the next state SHALL be IDLE and prio SHALL become !k.
REQ-025 There is one bubble cycle (IDLE) between packets, including back-to-back packets from the same requester.
REQ-026 A single-beat packet (valid and last high together) SHALL be handled as a complete packet.
REQ-027 A deassertion of ink_valid mid-packet SHALL keep GRANTk and SHALL accept no beat in that cycle.
REQ-028 Throughput in GRANTk with out_ready held high SHALL be one beat per cycle.

Reset
REQ-029 With rst_n low, the block SHALL go to IDLE immediately, independent of clk.
REQ-030 Reset SHALL set prio=0, out_valid=0, out_data=0, out_last=0, out_src=0, in0_ready=0 and in1_ready=0.
REQ-031 Reset mid-packet SHALL discard the packet and any pending output beat; after release, arbitration SHALL restart from IDLE.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2) and the WIDTH default.
REQ-033 Data selection SHALL instantiate the existing multiplexer_16 sub-module (select=0 passes requester 0, select=1 passes requester 1), with select driven by the grant.

Verification
REQ-034 Only requester 0 sends a 1-beat packet, 16'd256, with out_ready=1 -> out_data=256 and out_src=0 appear two cycles after valid is asserted.
REQ-035 Both requesters send 1-beat packets (256 and 1024) repeatedly after reset -> output order is 256, 1024, 256, 1024.
REQ-036 Requester 1 sends a 3-beat packet (1, 2, 3) while requester 0 is valid throughout -> all three beats go out with src=1 before any src=0 beat.
REQ-037 out_ready is held low for 4 cycles mid-packet -> out_data holds stable, in_ready stays low, and no beat is lost or duplicated.
REQ-038 rst_n is pulsed low mid-packet -> outputs clear asynchronously, and the next packet from requester 0 is granted first.
